seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor.
- Adds two WIDTH-bit operands CHUNK bits per clock, holding the ripple carry in a register between chunks.
- Trades latency for a short carry chain, so wide datapaths (64-bit and up) meet timing that a flat ripple-carry adder cannot.
- Uses a start/busy/done handshake; adds subtract mode and signed-overflow reporting.

Parameters:
- WIDTH, 64, operand and result width; must be a multiple of CHUNK.
- CHUNK, 16, bits added per cycle; must be >= 1. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- sub  input  1  0: a+b+carryInput; 1: a+~b+1 (carryInput ignored); sampled at acceptance.
- a  input  WIDTH  first operand; sampled at acceptance.
- b  input  WIDTH  second operand; sampled at acceptance.
- carryInput  input  1  carry-in for add mode; sampled at acceptance.
- sum  output  WIDTH  result; registered; holds the last completed result.
- carryOutput  output  1  carry out of the MSB (sub mode: 1 = no borrow).
- overflow  output  1  two's-complement signed overflow of the last result.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when sum, carryOutput and overflow are updated.

Behaviour:
- Reset (rst=0 at a rising edge):
  - sum=0, carryOutput=0, overflow=0, busy=0, done=0.
  - FSM returns to IDLE; chunk counter and carry register are cleared.
  - Reset takes priority over every other input.
- FSM has two states, IDLE and RUN.
- IDLE:
  - At an edge with start=1, latch a, b' (b' = sub ? ~b : b) and the carry (sub ? 1 : carryInput).
  - Clear the chunk index k to 0, go to RUN, and set busy=1.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Compute chunk k: {c, r} = a[k] + b'[k] + carry, each operand slice being CHUNK bits.
  - Store r into the internal accumulator slice k, set carry <= c, and k <= k+1.
- Completion, at the edge that processes chunk NCHUNK-1:
  - sum <= full accumulator including the final chunk; carryOutput <= c.
  - overflow <= (a_msb == b'_msb) && (sum_msb != a_msb).
  - done <= 1, busy <= 0, go to IDLE.
- Latency: acceptance edge T, chunk edges T+1..T+NCHUNK; done is high during the cycle after edge T+NCHUNK. Throughput is one operation per NCHUNK+1 edges.
- When NCHUNK=1, the operation completes at edge T+1.
- Output visibility:
  - sum, carryOutput and overflow change only at completion or reset.
  - During RUN they hold the previous result; partial sums are never visible.
- done is high for exactly one cycle. It clears on the next edge unless another completion occurs.
- start while busy=1 is ignored; it is not queued and does not corrupt operands.
- start in the same cycle as done=1: busy is already 0, so the request is accepted.
- Changing a, b, sub or carryInput during RUN has no effect on the result.
- Reset mid-RUN aborts the operation: no done pulse is issued and outputs go to zero.
- Carry propagation across chunk boundaries must match a flat WIDTH-bit addition exactly, including the full-carry-chain case.
- Width rule: all internal arithmetic is CHUNK+1 bits wide; the carry register is 1 bit.

Test Plan:
- Add, WIDTH=64, CHUNK=16: a=28, b=65, sub=0, carryInput=0, start=1 → after 4 chunk edges done=1, sum=93, carryOutput=0, overflow=0; busy high for exactly 4 cycles.
- Full carry chain: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, carryInput=0 → sum=0, carryOutput=1, overflow=0.
- Signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1 → sum=64'h8000_0000_0000_0000, carryOutput=0, overflow=1.
- Subtract with borrow:
  - sub=1, a=5, b=7, carryInput=1 (ignored) → sum=64'hFFFF_FFFF_FFFF_FFFE, carryOutput=0, overflow=0.
  - Then sub=1, a=7, b=5 → sum=2, carryOutput=1.
- Handshake and reset:
  - start=1 re-asserted while busy with different operands → ignored; the first result completes unchanged.
  - rst=0 after 2 chunk edges of a new operation → all outputs 0, no done pulse.
  - A following start with a=16, b=16 → sum=32.
- Parameter sweep, each against a flat reference sum:
  - WIDTH=16, CHUNK=4: a=4517, b=322, carryInput=1 → sum=4840, done 4 edges after acceptance.
  - WIDTH=16, CHUNK=4: a=32768, b=32768 → sum=0, carryOutput=1, overflow=1.
  - WIDTH=8, CHUNK=8: a=8'hFF, b=8'hFF → sum=8'hFE, carryOutput=1, done after 1 edge.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// Chunked multi-cycle adder/subtractor: CHUNK bits per clock with a registered ripple carry between chunks.
// Latency: acceptance edge T, chunk edges T+1..T+NCHUNK, done pulses during the cycle after edge T+NCHUNK.
// Backpressure: start is taken only while busy=0; requests during RUN are dropped, not queued.
module seq_chunk_adder #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryInput,
    output logic [WIDTH-1:0] sum,
    output logic             carryOutput,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // Counter is at least one bit wide so NCHUNK=1 still elaborates cleanly.
    localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Operands are shifted right one chunk per cycle, so the active slice is
    // always the low CHUNK bits and no wide operand mux sits in the carry path.
    state_t           state_q,  state_d;
    logic [KW-1:0]    k_q,      k_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             a_msb_q,  a_msb_d;
    logic             b_msb_q,  b_msb_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;
    logic             done_q,   done_d;

    // Datapath scratch values, all combinational.
    logic [WIDTH-1:0]       b_eff;
    logic [CHUNK:0]         chunk_res;
    logic [WIDTH+CHUNK-1:0] acc_cat;

    // State register: synchronous active-low reset clears everything, including any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: accept in IDLE, add one chunk per RUN cycle, publish results on the last chunk.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        // Subtraction is a + ~b + 1; the +1 rides in on the initial carry.
        b_eff     = sub ? ~b : b;
        // CHUNK+1 bits: the top bit is the carry into the next chunk.
        chunk_res = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_q};
        // New chunk enters at the top of the accumulator; after NCHUNK
        // shifts chunk 0 has reached bit 0.
        acc_cat   = {chunk_res[CHUNK-1:0], acc_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_eff;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b_eff[WIDTH-1];
                    carry_d = sub ? 1'b1 : carryInput;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = chunk_res[CHUNK];
                acc_d   = acc_cat[WIDTH+CHUNK-1:CHUNK];
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    // The final chunk's sum bit is the result MSB, so
                    // overflow needs no access to the assembled word.
                    sum_d   = acc_cat[WIDTH+CHUNK-1:CHUNK];
                    cout_d  = chunk_res[CHUNK];
                    ovf_d   = (a_msb_q == b_msb_q) && (chunk_res[CHUNK-1] != a_msb_q);
                    done_d  = 1'b1;
                    k_d     = '0;
                    carry_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sum         = sum_q;
    assign carryOutput = cout_q;
    assign overflow    = ovf_q;
    assign busy        = (state_q == RUN);
    assign done        = done_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
`timescale 1ns/1ps
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  start_v;
    logic        sub_i;
    logic [63:0] a_i;
    logic [63:0] b_i;
    logic        cin_i;

    logic [63:0] sum0;
    logic [15:0] sum1;
    logic [7:0]  sum2;
    logic [2:0]  co_v, ov_v, busy_v, done_v;

    seq_chunk_adder #(.WIDTH(64), .CHUNK(16)) u_w64 (
        .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_i), .a(a_i), .b(b_i),
        .carryInput(cin_i), .sum(sum0), .carryOutput(co_v[0]), .overflow(ov_v[0]),
        .busy(busy_v[0]), .done(done_v[0]));

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_w16 (
        .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_i), .a(a_i[15:0]), .b(b_i[15:0]),
        .carryInput(cin_i), .sum(sum1), .carryOutput(co_v[1]), .overflow(ov_v[1]),
        .busy(busy_v[1]), .done(done_v[1]));

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_w8 (
        .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_i), .a(a_i[7:0]), .b(b_i[7:0]),
        .carryInput(cin_i), .sum(sum2), .carryOutput(co_v[2]), .overflow(ov_v[2]),
        .busy(busy_v[2]), .done(done_v[2]));

    // View of the instance currently under test.
    int          cur_sel;
    logic [63:0] sel_sum;
    logic        sel_co, sel_ov, sel_busy, sel_done;
    always_comb begin
        sel_sum  = sum0;
        sel_co   = co_v[0];
        sel_ov   = ov_v[0];
        sel_busy = busy_v[0];
        sel_done = done_v[0];
        if (cur_sel == 1) begin
            sel_sum  = {48'd0, sum1};
            sel_co   = co_v[1];
            sel_ov   = ov_v[1];
            sel_busy = busy_v[1];
            sel_done = done_v[1];
        end else if (cur_sel == 2) begin
            sel_sum  = {56'd0, sum2};
            sel_co   = co_v[2];
            sel_ov   = ov_v[2];
            sel_busy = busy_v[2];
            sel_done = done_v[2];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Launch one operation on instance sel and wait for done.
    // now=1 raises start in the current cycle (used for back-to-back issue).
    task automatic run_op(input int sel, input bit now, input logic s,
                          input logic [63:0] av, input logic [63:0] bv, input logic ci,
                          output logic [63:0] rs, output logic rco, output logic rov,
                          output int lat, output int bcnt, output bit ok, output bit hold_ok);
        logic [63:0] ref_sum;
        logic        ref_co, ref_ov;
        cur_sel = sel;
        if (!now) @(negedge clk);
        start_v = 3'b000;
        start_v[sel] = 1'b1;
        sub_i = s; a_i = av; b_i = bv; cin_i = ci;
        @(negedge clk);
        start_v = 3'b000;
        lat = 0; bcnt = 0; ok = 1'b0; hold_ok = 1'b1;
        ref_sum = sel_sum; ref_co = sel_co; ref_ov = sel_ov;
        check("done_one_cycle", {63'd0, sel_done}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            if (sel_busy) bcnt++;
            if (sel_done) begin
                ok = 1'b1;
                break;
            end
            if (sel_sum !== ref_sum || sel_co !== ref_co || sel_ov !== ref_ov) hold_ok = 1'b0;
            // Operand changes during RUN must not affect the result.
            a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom};
            sub_i = 1'($urandom); cin_i = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        rs = sel_sum; rco = sel_co; rov = sel_ov;
    endtask

    typedef struct {
        int          sel;
        logic        sub;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] exp_sum;
        logic        exp_co;
        logic        exp_ov;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [63:0] rs;
        logic        rco, rov;
        int          lat, bcnt, dcnt;
        bit          ok, hold_ok;

        vecs[0]  = '{0, 1'b0, 64'd28, 64'd65, 1'b0, 64'd93, 1'b0, 1'b0, 4};
        vecs[1]  = '{0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 4};
        vecs[2]  = '{0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 4};
        vecs[3]  = '{0, 1'b1, 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4};
        vecs[4]  = '{0, 1'b1, 64'd7, 64'd5, 1'b0, 64'd2, 1'b1, 1'b0, 4};
        vecs[5]  = '{0, 1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 4};
        vecs[6]  = '{0, 1'b0, 64'h0000_FFFF_0000_FFFF, 64'd0, 1'b1, 64'h0000_FFFF_0001_0000, 1'b0, 1'b0, 4};
        vecs[7]  = '{1, 1'b0, 64'd4517, 64'd322, 1'b1, 64'd4840, 1'b0, 1'b0, 4};
        vecs[8]  = '{1, 1'b0, 64'd32768, 64'd32768, 1'b0, 64'd0, 1'b1, 1'b1, 4};
        vecs[9]  = '{1, 1'b1, 64'd0, 64'd1, 1'b0, 64'hFFFF, 1'b0, 1'b0, 4};
        vecs[10] = '{2, 1'b0, 64'hFF, 64'hFF, 1'b0, 64'hFE, 1'b1, 1'b0, 1};
        vecs[11] = '{2, 1'b1, 64'h80, 64'h01, 1'b0, 64'h7F, 1'b1, 1'b1, 1};

        rst = 1'b0; start_v = 3'b000; sub_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
        cur_sel = 0;
        repeat (3) @(negedge clk);

        // Reset state of every instance.
        check("rst_sum", sum0 | {48'd0, sum1} | {56'd0, sum2}, 64'd0);
        check("rst_co", {61'd0, co_v}, 64'd0);
        check("rst_ov", {61'd0, ov_v}, 64'd0);
        check("rst_busy", {61'd0, busy_v}, 64'd0);
        check("rst_done", {61'd0, done_v}, 64'd0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].sel, 1'b0, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin,
                   rs, rco, rov, lat, bcnt, ok, hold_ok);
            check($sformatf("v%0d_done_seen", i), {63'd0, ok}, 64'd1);
            check($sformatf("v%0d_sum", i), rs, vecs[i].exp_sum);
            check($sformatf("v%0d_co", i), {63'd0, rco}, {63'd0, vecs[i].exp_co});
            check($sformatf("v%0d_ov", i), {63'd0, rov}, {63'd0, vecs[i].exp_ov});
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'(vecs[i].exp_lat));
            check($sformatf("v%0d_hold", i), {63'd0, hold_ok}, 64'd1);
        end

        // Start re-asserted while busy with other operands is ignored.
        cur_sel = 0;
        @(negedge clk);
        start_v = 3'b001; sub_i = 1'b0; cin_i = 1'b0;
        a_i = 64'h8000_0000_0000_0064; b_i = 64'h8000_0000_0000_00C8;
        @(negedge clk);
        a_i = 64'd1; b_i = 64'd1; sub_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start_v = 3'b000;
        lat = 2; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done_v[0]) begin ok = 1'b1; break; end
            @(negedge clk);
            lat++;
        end
        check("busy_start_done_seen", {63'd0, ok}, 64'd1);
        check("busy_start_latency", 64'(lat), 64'd4);
        check("busy_start_sum", sum0, 64'h0000_0000_0000_012C);
        check("busy_start_co", {63'd0, co_v[0]}, 64'd1);
        check("busy_start_ov", {63'd0, ov_v[0]}, 64'd1);
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_v[0]) dcnt++;
        end
        check("busy_start_not_queued", 64'(dcnt), 64'd0);

        // Reset two chunk edges into an operation aborts it.
        start_v = 3'b001; a_i = 64'h1234; b_i = 64'd1; sub_i = 1'b0;
        @(negedge clk);
        start_v = 3'b000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_sum", sum0, 64'd0);
        check("abort_co", {63'd0, co_v[0]}, 64'd0);
        check("abort_ov", {63'd0, ov_v[0]}, 64'd0);
        check("abort_busy", {63'd0, busy_v[0]}, 64'd0);
        rst = 1'b1;
        dcnt = 0;
        repeat (6) begin
            if (done_v[0]) dcnt++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(dcnt), 64'd0);
        run_op(0, 1'b0, 1'b0, 64'd16, 64'd16, 1'b0, rs, rco, rov, lat, bcnt, ok, hold_ok);
        check("post_abort_sum", rs, 64'd32);
        check("post_abort_latency", 64'(lat), 64'd4);

        // Start during the done cycle is accepted immediately.
        run_op(0, 1'b0, 1'b0, 64'd3, 64'd4, 1'b0, rs, rco, rov, lat, bcnt, ok, hold_ok);
        check("b2b_first_sum", rs, 64'd7);
        run_op(0, 1'b1, 1'b0, 64'd10, 64'd20, 1'b0, rs, rco, rov, lat, bcnt, ok, hold_ok);
        check("b2b_second_done_seen", {63'd0, ok}, 64'd1);
        check("b2b_second_sum", rs, 64'd30);
        check("b2b_second_latency", 64'(lat), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
